sfq_toggle_rx: RTL and testbench

- Clocked receiver for a toggle-encoded SFQ pulse line, such as the output of a JTL cell model. In that encoding, every level change on the line is one SFQ pulse.
- Sits at the digital end of the RSFQ behavioural chain. It turns pulse arrivals within strobe-delimited bit windows into WIDTH-bit words.
- Words are delivered through a 2-entry valid/ready output buffer.
- Sticky flags report lost words and malformed windows.

---
 rtl/sfq_toggle_rx.sv | 176 +++++++++++++++++
 tb/tb_sfq_toggle_rx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sfq_toggle_rx.sv
// rtl/sfq_toggle_rx.sv - toggle-encoded SFQ line receiver with strobe-framed words and 2-entry output buffer
module sfq_toggle_rx #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pulse_in,
    input  logic                       frame_start,
    input  logic                       bit_strobe,
    output logic [WIDTH-1:0]           data_out,
    output logic                       data_valid,
    input  logic                       data_ready,
    output logic [$clog2(WIDTH+1)-1:0] bit_count,
    output logic                       overflow,
    output logic                       pulse_err
);

    localparam int CW = $clog2(WIDTH+1);
    localparam int AW = $clog2(SYNC_STAGES+2);
    localparam logic [AW-1:0] ARM_DONE = AW'(SYNC_STAGES+1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH-1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [AW-1:0]          arm_q;
    logic                   armed;
    logic                   pulse_det;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-2:0] shreg_q, shreg_d;
    logic             hit_q, hit_d;
    logic             multi_q, multi_d;
    logic             bit_v;
    logic [WIDTH-1:0] word;
    logic             push;
    logic             err_set;

    logic [WIDTH-1:0] mem_q [2];
    logic             rd_q, wr_q;
    logic [1:0]       fcnt_q;
    logic             pop;
    logic             full;
    logic             push_ok;
    logic             overflow_q;
    logic             pulse_err_q;

    // The arm counter hides the edge seen while the synchroniser fills after reset.
    assign armed     = (arm_q == ARM_DONE);
    assign pulse_det = armed & (sync_q[SYNC_STAGES-1] ^ prev_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            arm_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
            prev_q <= sync_q[SYNC_STAGES-1];
            if (!armed) begin
                arm_q <= arm_q + AW'(1);
            end
        end
    end

    // The closing strobe's own cycle still counts as part of the window.
    assign bit_v = hit_q | pulse_det;
    assign word  = {bit_v, shreg_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        hit_d   = hit_q;
        multi_d = multi_q;
        push    = 1'b0;
        err_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    hit_d   = 1'b0;
                    multi_d = 1'b0;
                end
            end
            default: begin
                if (bit_strobe && (cnt_q == LAST_BIT)) begin
                    push    = 1'b1;
                    err_set = multi_q | (hit_q & pulse_det);
                    cnt_d   = '0;
                    hit_d   = 1'b0;
                    multi_d = 1'b0;
                    state_d = frame_start ? SHIFT : IDLE;
                end else if (frame_start) begin
                    cnt_d   = '0;
                    hit_d   = 1'b0;
                    multi_d = 1'b0;
                end else if (bit_strobe) begin
                    shreg_d = word[WIDTH-1:1];
                    err_set = multi_q | (hit_q & pulse_det);
                    cnt_d   = cnt_q + CW'(1);
                    hit_d   = 1'b0;
                    multi_d = 1'b0;
                end else if (pulse_det) begin
                    hit_d   = 1'b1;
                    multi_d = multi_q | hit_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            hit_q   <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            hit_q   <= hit_d;
            multi_q <= multi_d;
        end
    end

    // When full, wr_q equals rd_q, so a simultaneous pop frees exactly the slot being written.
    assign pop     = (fcnt_q != 2'd0) & data_ready;
    assign full    = (fcnt_q == 2'd2);
    assign push_ok = push & (~full | pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            fcnt_q      <= 2'd0;
            overflow_q  <= 1'b0;
            pulse_err_q <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= word;
                wr_q        <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            if (push_ok && !pop) begin
                fcnt_q <= fcnt_q + 2'd1;
            end else if (pop && !push_ok) begin
                fcnt_q <= fcnt_q - 2'd1;
            end
            if (push && full && !pop) begin
                overflow_q <= 1'b1;
            end
            if (err_set) begin
                pulse_err_q <= 1'b1;
            end
        end
    end

    assign data_out   = mem_q[rd_q];
    assign data_valid = (fcnt_q != 2'd0);
    assign bit_count  = cnt_q;
    assign overflow   = overflow_q;
    assign pulse_err  = pulse_err_q;

endmodule

// File: tb/tb_sfq_toggle_rx.sv
// tb/tb_sfq_toggle_rx.sv - directed self-checking bench for sfq_toggle_rx
module tb_sfq_toggle_rx;

    logic       clk;
    logic       rst_n;
    logic       pulse_in;
    logic       frame_start;
    logic       bit_strobe;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic [3:0] bit_count;
    logic       overflow;
    logic       pulse_err;

    int checks = 0;
    int errors = 0;

    sfq_toggle_rx #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pulse_in    (pulse_in),
        .frame_start (frame_start),
        .bit_strobe  (bit_strobe),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .bit_count   (bit_count),
        .overflow    (overflow),
        .pulse_err   (pulse_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Each toggle reaches the FSM three edges later, well before this window's strobe.
    task automatic window(input int ntog);
        for (int t = 0; t < ntog; t++) begin
            pulse_in = ~pulse_in;
            tick();
        end
        repeat (3) tick();
        bit_strobe = 1'b1;
        tick();
        bit_strobe = 1'b0;
    endtask

    task automatic window_coinc();
        pulse_in = ~pulse_in;
        tick();
        tick();
        bit_strobe = 1'b1;
        tick();
        bit_strobe = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        frame();
        for (int b = 0; b < 8; b++) begin
            window(w[b] ? 1 : 0);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        pulse_in    = 1'b1;
        frame_start = 1'b0;
        bit_strobe  = 1'b0;
        data_ready  = 1'b1;
        repeat (3) tick();
        chk("rst_data_out", 32'(data_out), 32'h00);
        chk("rst_data_valid", 32'(data_valid), 32'h0);
        chk("rst_bit_count", 32'(bit_count), 32'h0);
        chk("rst_flags", {30'd0, overflow, pulse_err}, 32'h0);

        // Static-high line at release: a frame opened immediately must not see a pulse.
        rst_n = 1'b1;
        frame();
        for (int b = 0; b < 8; b++) begin
            window(0);
        end
        chk("arm_valid", 32'(data_valid), 32'h1);
        chk("arm_word", 32'(data_out), 32'h00);
        repeat (10) tick();
        chk("idle_valid", 32'(data_valid), 32'h0);
        chk("idle_pulse_err", 32'(pulse_err), 32'h0);
        chk("idle_bit_count", 32'(bit_count), 32'h0);

        frame();
        window(1); window(0); window(1);
        chk("mid_bit_count", 32'(bit_count), 32'h3);
        window(0); window(0); window(1); window(0); window(1);
        chk("a5_valid", 32'(data_valid), 32'h1);
        chk("a5_word", 32'(data_out), 32'hA5);
        chk("a5_bit_count", 32'(bit_count), 32'h0);
        tick();
        chk("a5_one_cycle", 32'(data_valid), 32'h0);

        frame();
        window(0); window(0); window(0);
        window_coinc();
        window(0); window(0); window(0); window(0);
        chk("coinc_valid", 32'(data_valid), 32'h1);
        chk("coinc_word", 32'(data_out), 32'h08);
        chk("coinc_pulse_err", 32'(pulse_err), 32'h0);
        tick();

        frame();
        window(0); window(2);
        chk("multi_err_set", 32'(pulse_err), 32'h1);
        window(0); window(0); window(0); window(0); window(0); window(0);
        chk("multi_word", 32'(data_out), 32'h02);
        chk("multi_valid", 32'(data_valid), 32'h1);
        tick();

        data_ready = 1'b0;
        send_word(8'h11);
        send_word(8'h22);
        chk("ovf_not_yet", 32'(overflow), 32'h0);
        send_word(8'h33);
        chk("ovf_set", 32'(overflow), 32'h1);
        chk("ovf_head", 32'(data_out), 32'h11);
        data_ready = 1'b1;
        tick();
        chk("ovf_second", 32'(data_out), 32'h22);
        chk("ovf_second_valid", 32'(data_valid), 32'h1);
        tick();
        chk("ovf_drained", 32'(data_valid), 32'h0);
        chk("ovf_sticky", 32'(overflow), 32'h1);
        chk("err_sticky", 32'(pulse_err), 32'h1);

        frame();
        window(1); window(1); window(1); window(1);
        chk("abort_count_before", 32'(bit_count), 32'h4);
        frame();
        chk("abort_count_after", 32'(bit_count), 32'h0);
        chk("abort_no_push", 32'(data_valid), 32'h0);
        for (int b = 0; b < 8; b++) begin
            window(((8'h3C >> b) & 8'h01) != 0 ? 1 : 0);
        end
        chk("abort_word_valid", 32'(data_valid), 32'h1);
        chk("abort_word", 32'(data_out), 32'h3C);
        tick();
        chk("abort_only_one", 32'(data_valid), 32'h0);

        frame();
        window(1); window(0); window(1); window(1); window(0);
        chk("rst_mid_count", 32'(bit_count), 32'h5);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_data_out", 32'(data_out), 32'h00);
        chk("rst_mid_bit_count", 32'(bit_count), 32'h0);
        chk("rst_mid_flags", {30'd0, overflow, pulse_err}, 32'h0);
        chk("rst_mid_valid", 32'(data_valid), 32'h0);
        tick();
        rst_n = 1'b1;
        window(1); window(0); window(1);
        chk("post_rst_idle_count", 32'(bit_count), 32'h0);
        chk("post_rst_no_word", 32'(data_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
